// File: rtl/proc_trace_pkg.sv
// Shared types for the commit-trace buffer: record layout and default depth.
// The jump field is always present so the record layout is fixed across builds.
package proc_trace_pkg;

    localparam int TRACE_DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] data;
        logic        jump;
    } trace_rec_t;

endpackage

// File: rtl/proc_trace_fifo_mem.sv
// Trace record storage: DEPTH x trace_rec_t register array.
// One synchronous write port and one combinational read port.
module proc_trace_fifo_mem
    import proc_trace_pkg::*;
#(
    parameter  int DEPTH = TRACE_DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  trace_rec_t       wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output trace_rec_t       rdata_o
);

    trace_rec_t mem_q [DEPTH];

    // Storage is not reset; the top masks the read data while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/proc_trace_buf.sv
// Commit-trace buffer: queues retired-instruction records and drains them over val/rdy.
// Full-FIFO records are dropped and counted. PROC_TRACE_JUMP_FLAG_EN enables jump flagging.
module proc_trace_buf
    import proc_trace_pkg::*;
#(
    parameter  int DEPTH  = TRACE_DEFAULT_DEPTH,
    parameter  int DROP_W = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trace_val,
    input  logic [31:0]       trace_addr,
    input  logic [31:0]       trace_inst,
    input  logic [31:0]       trace_data,
    output logic              deq_val,
    input  logic              deq_rdy,
    output logic [31:0]       deq_addr,
    output logic [31:0]       deq_inst,
    output logic [31:0]       deq_data,
    output logic              deq_jump,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic       full;
    logic       deq_fire;
    logic       enq_fire;
    logic       drop;
    logic       jump_d;
    trace_rec_t wr_rec;
    trace_rec_t rd_rec;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign deq_val  = (count_q != '0);
    assign deq_fire = deq_val && deq_rdy;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign enq_fire = trace_val && (!full || deq_fire);
    assign drop     = trace_val && full && !deq_fire;

`ifdef PROC_TRACE_JUMP_FLAG_EN
    logic [31:0] prev_addr_q;
    logic        prev_valid_q;

    // Every observed record updates the history, dropped ones included.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_addr_q  <= '0;
            prev_valid_q <= 1'b0;
        end else if (trace_val) begin
            prev_addr_q  <= trace_addr;
            prev_valid_q <= 1'b1;
        end
    end

    assign jump_d = prev_valid_q && (trace_addr != (prev_addr_q + 32'd4));
`else
    assign jump_d = 1'b0;
`endif

    assign wr_rec = '{addr: trace_addr, inst: trace_inst, data: trace_data, jump: jump_d};

    proc_trace_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (enq_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_rec),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_rec)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign deq_addr = deq_val ? rd_rec.addr : '0;
    assign deq_inst = deq_val ? rd_rec.inst : '0;
    assign deq_data = deq_val ? rd_rec.data : '0;
    assign deq_jump = deq_val ? rd_rec.jump : 1'b0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_proc_trace_buf.sv
// Self-checking bench for proc_trace_buf: vector table plus stream, reset and jump sequences.
// Expected jump flags follow PROC_TRACE_JUMP_FLAG_EN as defined for this build.
module tb_proc_trace_buf;

`ifdef PROC_TRACE_JUMP_FLAG_EN
    localparam logic JUMP_EN = 1'b1;
`else
    localparam logic JUMP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_inst;
    logic [31:0] trace_data;
    logic        deq_val;
    logic        deq_rdy;
    logic [31:0] deq_addr;
    logic [31:0] deq_inst;
    logic [31:0] deq_data;
    logic        deq_jump;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    proc_trace_buf #(
        .DEPTH  (8),
        .DROP_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trace_val  (trace_val),
        .trace_addr (trace_addr),
        .trace_inst (trace_inst),
        .trace_data (trace_data),
        .deq_val    (deq_val),
        .deq_rdy    (deq_rdy),
        .deq_addr   (deq_addr),
        .deq_inst   (deq_inst),
        .deq_data   (deq_data),
        .deq_jump   (deq_jump),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tv;
        logic [31:0] addr;
        logic        rdy;
        logic        exp_dv;
        logic [31:0] exp_addr;
        int          exp_cnt;
        int          exp_drop;
        logic        exp_ovf;
        logic        exp_jump;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        jump;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    function automatic logic [31:0] data_of(logic [31:0] a);
        return a * 32'd3 + 32'd5;
    endfunction

    function automatic void add(logic tv, logic [31:0] addr, logic rdy, logic dv,
                                logic [31:0] haddr, int cnt, int drp, logic ovf, logic hj);
        vec_t v;
        v.tv = tv; v.addr = addr; v.rdy = rdy; v.exp_dv = dv; v.exp_addr = haddr;
        v.exp_cnt = cnt; v.exp_drop = drp; v.exp_ovf = ovf; v.exp_jump = hj;
        vecs.push_back(v);
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void chk_head(string name, logic [31:0] a, logic j);
        chk({name, "_val"},  {31'd0, deq_val}, 32'd1);
        chk({name, "_addr"}, deq_addr, a);
        chk({name, "_inst"}, deq_inst, inst_of(a));
        chk({name, "_data"}, deq_data, data_of(a));
        chk({name, "_jump"}, {31'd0, deq_jump}, {31'd0, j & JUMP_EN});
    endfunction

    task automatic drive(logic tv, logic [31:0] a, logic rdy);
        trace_val  = tv;
        trace_addr = a;
        trace_inst = inst_of(a);
        trace_data = data_of(a);
        deq_rdy    = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] jaddr [5];
    logic        jexp  [5];

    initial begin
        int sent;
        int got;
        sb_t e;

        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0);
        step();
        step();
        rst = 1'b0;

        chk("rst_val",  {31'd0, deq_val}, 32'd0);
        chk("rst_cnt",  {28'd0, count}, 32'd0);
        chk("rst_ovf",  {31'd0, overflow}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("rst_addr", deq_addr, 32'd0);

        // tv, addr, rdy | dv, head, cnt, drop, ovf, head jump (outputs seen before this edge)
        add(1, 32'h00, 1,  0, 32'h00, 0, 0, 0, 0);
        add(0, 32'h00, 1,  1, 32'h00, 1, 0, 0, 0);
        add(1, 32'h00, 0,  0, 32'h00, 0, 0, 0, 0);
        add(1, 32'h04, 0,  1, 32'h00, 1, 0, 0, 1);
        add(1, 32'h08, 0,  1, 32'h00, 2, 0, 0, 1);
        add(1, 32'h0C, 0,  1, 32'h00, 3, 0, 0, 1);
        add(1, 32'h10, 0,  1, 32'h00, 4, 0, 0, 1);
        add(1, 32'h14, 0,  1, 32'h00, 5, 0, 0, 1);
        add(1, 32'h18, 0,  1, 32'h00, 6, 0, 0, 1);
        add(1, 32'h1C, 0,  1, 32'h00, 7, 0, 0, 1);
        add(1, 32'h20, 0,  1, 32'h00, 8, 0, 0, 1);
        add(1, 32'h40, 1,  1, 32'h00, 8, 1, 1, 1);
        add(0, 32'h00, 1,  1, 32'h04, 8, 1, 1, 0);
        add(0, 32'h00, 0,  1, 32'h08, 7, 1, 1, 0);
        add(0, 32'h00, 1,  1, 32'h08, 7, 1, 1, 0);
        add(0, 32'h00, 1,  1, 32'h0C, 6, 1, 1, 0);
        add(0, 32'h00, 1,  1, 32'h10, 5, 1, 1, 0);
        add(0, 32'h00, 1,  1, 32'h14, 4, 1, 1, 0);
        add(0, 32'h00, 1,  1, 32'h18, 3, 1, 1, 0);
        add(0, 32'h00, 1,  1, 32'h1C, 2, 1, 1, 0);
        add(0, 32'h00, 1,  1, 32'h40, 1, 1, 1, 1);
        add(0, 32'h00, 1,  0, 32'h00, 0, 1, 1, 0);
        add(0, 32'h00, 0,  0, 32'h00, 0, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].tv, vecs[i].addr, vecs[i].rdy);
            $display("vec %0d: tv=%0b addr=0x%02h rdy=%0b -> dv=%0b head=0x%02h cnt=%0d drop=%0d",
                     i, vecs[i].tv, vecs[i].addr, vecs[i].rdy, deq_val, deq_addr, count, drop_cnt);
            chk($sformatf("vec%0d_cnt", i),  {28'd0, count}, 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_drop", i), {16'd0, drop_cnt}, 32'(vecs[i].exp_drop));
            chk($sformatf("vec%0d_ovf", i),  {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
            if (vecs[i].exp_dv) begin
                chk_head($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_jump);
            end else begin
                chk($sformatf("vec%0d_val", i),  {31'd0, deq_val}, 32'd0);
                chk($sformatf("vec%0d_addr", i), deq_addr, 32'd0);
                chk($sformatf("vec%0d_jump", i), {31'd0, deq_jump}, 32'd0);
            end
            step();
        end

        // 1-in/1-out stream through the pointer wrap; previous record was 0x40.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
            chk("stream_cnt_le1", {31'd0, (count <= 4'd1)}, 32'd1);
            if (deq_val) begin
                if (sb_q.size() == 0) begin
                    chk("stream_unexpected", deq_addr, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk_head($sformatf("stream%0d", got), e.addr, e.jump);
                    $display("stream %0d: head=0x%03h jump=%0b cnt=%0d", got, deq_addr, deq_jump, count);
                end
                got++;
            end
            if (sent < 20) begin
                e.addr = 32'h100 + 32'(sent) * 32'd4;
                e.jump = (sent == 0);
                sb_q.push_back(e);
                drive(1'b1, e.addr, 1'b1);
                sent++;
            end else begin
                drive(1'b0, 32'd0, 1'b1);
            end
            step();
        end
        chk("stream_got", 32'(got), 32'd20);
        chk("stream_end_cnt", {28'd0, count}, 32'd0);

        // Reset with five entries queued; the record seen during reset must not seed the history.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h200 + 32'(i) * 32'd4, 1'b0);
            step();
        end
        chk("prerst_cnt", {28'd0, count}, 32'd5);
        chk("prerst_drop", {16'd0, drop_cnt}, 32'd1);
        rst = 1'b1;
        drive(1'b1, 32'h300, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        $display("reset: dv=%0b cnt=%0d drop=%0d ovf=%0b", deq_val, count, drop_cnt, overflow);
        chk("midrst_val",  {31'd0, deq_val}, 32'd0);
        chk("midrst_cnt",  {28'd0, count}, 32'd0);
        chk("midrst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("midrst_ovf",  {31'd0, overflow}, 32'd0);

        // Jump sequence: sequential, sequential, jr, jr to self, sequential.
        jaddr = '{32'h000, 32'h004, 32'h010, 32'h010, 32'h014};
        jexp  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, jaddr[i], 1'b0);
            step();
        end
        drive(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            $display("jump %0d: head=0x%03h jump=%0b", i, deq_addr, deq_jump);
            chk_head($sformatf("jump%0d", i), jaddr[i], jexp[i]);
            step();
        end
        chk("jump_end_cnt", {28'd0, count}, 32'd0);
        chk("jump_end_ovf", {31'd0, overflow}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
